hamming_encoder_tx: RTL and testbench

//  Upstream stage of decoder_hamming. Encodes 11-bit data words into the 16-bit

---
 rtl/hamming_encoder_tx_if.sv | 24 ++
 rtl/hamming_encoder_tx.sv | 105 ++++++++++
 tb/tb_hamming_encoder_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_encoder_tx_if.sv
// Handshake bundle between a data source, the Hamming encoder and its downstream decoder.
// The slave modport is the encoder's view; master is the source/sink driving it.
interface hamming_encoder_tx_if;
   logic [0:10] data_in;
   logic        in_valid;
   logic        in_ready;
   logic        inj_en;
   logic        inj_double;
   logic [3:0]  inj_pos_a;
   logic [3:0]  inj_pos_b;
   logic [0:15] c_h;
   logic        out_valid;
   logic        out_ready;

   modport slave (
      input  data_in, in_valid, inj_en, inj_double, inj_pos_a, inj_pos_b, out_ready,
      output in_ready, c_h, out_valid
   );

   modport master (
      output data_in, in_valid, inj_en, inj_double, inj_pos_a, inj_pos_b, out_ready,
      input  in_ready, c_h, out_valid
   );
endinterface

// File: rtl/hamming_encoder_tx.sv
// SECDED (16,11) Hamming encoder with optional 1/2-bit error injection, feeding a
// 2-entry output FIFO, plus wrap-around counters for sent words and injected words.
module hamming_encoder_tx #(
   parameter int CNT_W      = 16,
   parameter bit INJ_ENABLE = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   hamming_encoder_tx_if.slave  bus,
   output logic [CNT_W-1:0]     words_sent,
   output logic [CNT_W-1:0]     inj_count
);

   // Index 0 is the MSB of every [0:N] vector, matching the decoder's layout.
   function automatic logic [0:15] encode(input logic [0:10] d);
      logic [0:15] c;
      c       = '0;
      c[2]    = d[0];
      c[4]    = d[1];
      c[5]    = d[2];
      c[6]    = d[3];
      c[8:14] = d[4:10];
      c[0]    = ^{c[2], c[4], c[6], c[8], c[10], c[12], c[14]};
      c[1]    = ^{c[2], c[5], c[6], c[9], c[10], c[13], c[14]};
      c[3]    = ^{c[4], c[5], c[6], c[11], c[12], c[13], c[14]};
      c[7]    = ^c[8:14];
      c[15]   = ^c[0:14];
      return c;
   endfunction

   logic [0:15]      mem_q [2];
   logic [0:15]      mem_d [2];
   logic             wrPtr_q, wrPtr_d;
   logic             rdPtr_q, rdPtr_d;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] wordsSent_q, wordsSent_d;
   logic [CNT_W-1:0] injCount_q, injCount_d;

   logic             push;
   logic             pop;
   logic             injActive;
   logic [0:15]      injMask;
   logic [0:15]      encWord;

   assign bus.in_ready  = (count_q != 2'd2) & ~rst;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.c_h       = (count_q != 2'd0) ? mem_q[rdPtr_q] : '0;
   assign words_sent    = wordsSent_q;
   assign inj_count     = injCount_q;

   assign push      = bus.in_valid & bus.in_ready;
   assign pop       = bus.out_valid & bus.out_ready;
   assign injActive = INJ_ENABLE & bus.inj_en;

   // Masks are OR-ed, so equal positions give one flip rather than cancelling out.
   always_comb begin
      injMask = '0;
      if (injActive) begin
         injMask[bus.inj_pos_a] = 1'b1;
         if (bus.inj_double) begin
            injMask[bus.inj_pos_b] = 1'b1;
         end
      end
   end

   assign encWord = encode(bus.data_in) ^ injMask;

   always_comb begin
      mem_d[0]    = mem_q[0];
      mem_d[1]    = mem_q[1];
      wrPtr_d     = wrPtr_q ^ push;
      rdPtr_d     = rdPtr_q ^ pop;
      wordsSent_d = wordsSent_q + CNT_W'(pop);
      injCount_d  = injCount_q + CNT_W'(push & injActive);
      if (push) begin
         mem_d[wrPtr_q] = encWord;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         wrPtr_q     <= 1'b0;
         rdPtr_q     <= 1'b0;
         count_q     <= 2'd0;
         wordsSent_q <= '0;
         injCount_q  <= '0;
      end else begin
         mem_q[0]    <= mem_d[0];
         mem_q[1]    <= mem_d[1];
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         wordsSent_q <= wordsSent_d;
         injCount_q  <= injCount_d;
      end
   end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Scoreboard bench for hamming_encoder_tx: a driver pushes reference codewords on accept,
// a monitor pops and compares on every output handshake.
module tb_hamming_encoder_tx;

   logic        clk;
   logic        rst;
   logic [15:0] wordsSentA, injCountA;
   logic [3:0]  wordsSentB, injCountB;

   hamming_encoder_tx_if busA ();
   hamming_encoder_tx_if busB ();

   hamming_encoder_tx #(.CNT_W(16), .INJ_ENABLE(1'b1)) dutA (
      .clk(clk), .rst(rst), .bus(busA), .words_sent(wordsSentA), .inj_count(injCountA)
   );

   hamming_encoder_tx #(.CNT_W(4), .INJ_ENABLE(1'b0)) dutB (
      .clk(clk), .rst(rst), .bus(busB), .words_sent(wordsSentB), .inj_count(injCountB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [0:15] expQ [$];
   bit          pending = 1'b0;
   bit          pendInj = 1'b0;
   int          modelSent = 0;
   int          modelInj = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: parity bit at Hamming position p covers every position with bit p set.
   function automatic logic [0:15] refWord(input logic [0:10] d, input logic ie, input logic dbl,
                                           input logic [3:0] pa, input logic [3:0] pb);
      logic [0:15] c;
      int          k;
      bit          par;
      c = '0;
      k = 0;
      for (int pos = 1; pos <= 15; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            c[pos-1] = d[k];
            k++;
         end
      end
      for (int p = 1; p <= 8; p = p * 2) begin
         par = 1'b0;
         for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & p) != 0 && pos != p) par ^= c[pos-1];
         end
         c[p-1] = par;
      end
      par = 1'b0;
      for (int i = 0; i < 15; i++) par ^= c[i];
      c[15] = par;
      if (ie) begin
         c[pa] = ~c[pa];
         if (dbl && pb != pa) c[pb] = ~c[pb];
      end
      return c;
   endfunction

   task automatic applyStimulus(input logic [0:10] d, input logic v, input logic ie, input logic dbl,
                                input logic [3:0] pa, input logic [3:0] pb, input logic ordy);
      @(negedge clk);
      #1;
      if (pendInj) modelInj++;
      busA.data_in    = d;
      busA.in_valid   = v;
      busA.inj_en     = ie;
      busA.inj_double = dbl;
      busA.inj_pos_a  = pa;
      busA.inj_pos_b  = pb;
      busA.out_ready  = ordy;
      pending = v && busA.in_ready;
      pendInj = pending && ie;
      if (pending) expQ.push_back(refWord(d, ie, dbl, pa, pb));
   endtask

   task automatic idle(input logic ordy);
      applyStimulus(11'h000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, ordy);
   endtask

   task automatic directedWord(input string name, input logic [0:10] d, input logic ie,
                               input logic dbl, input logic [3:0] pa, input logic [3:0] pb,
                               input logic [15:0] expWord);
      applyStimulus(d, 1'b1, ie, dbl, pa, pb, 1'b1);
      idle(1'b1);
      checkOutput({name, "_valid"}, 32'(busA.out_valid), 32'd1);
      checkOutput(name, 32'(busA.c_h), 32'(expWord));
   endtask

   // Monitor: occupancy is the queue minus any word that is only about to be accepted.
   initial begin
      logic [0:15] expWord;
      int          occ;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            occ = expQ.size() - int'(pending);
            checkOutput("out_valid", 32'(busA.out_valid), 32'(occ != 0));
            checkOutput("in_ready", 32'(busA.in_ready), 32'(occ != 2));
            if (occ == 0) checkOutput("c_h_empty", 32'(busA.c_h), 32'd0);
            checkOutput("words_sent", 32'(wordsSentA), 32'(modelSent & 16'hFFFF));
            checkOutput("inj_count", 32'(injCountA), 32'(modelInj & 16'hFFFF));
            if (busA.out_valid && busA.out_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("sb_underflow", 32'd1, 32'd0);
               end else begin
                  expWord = expQ.pop_front();
                  checkOutput("sb_word", 32'(busA.c_h), 32'(expWord));
               end
               modelSent++;
            end
         end
      end
   end

   initial begin
      int hs;
      bit seenB;
      rst = 1'b1;
      busA.data_in = '0; busA.in_valid = 1'b0; busA.inj_en = 1'b0; busA.inj_double = 1'b0;
      busA.inj_pos_a = '0; busA.inj_pos_b = '0; busA.out_ready = 1'b0;
      busB.data_in = '0; busB.in_valid = 1'b0; busB.inj_en = 1'b0; busB.inj_double = 1'b0;
      busB.inj_pos_a = '0; busB.inj_pos_b = '0; busB.out_ready = 1'b0;

      #12;
      checkOutput("rst_in_ready_low", 32'(busA.in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset_in_ready", 32'(busA.in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(busA.out_valid), 32'd0);
      checkOutput("reset_c_h", 32'(busA.c_h), 32'd0);
      checkOutput("reset_words_sent", 32'(wordsSentA), 32'd0);

      directedWord("enc_000", 11'h000, 1'b0, 1'b0, 4'd0, 4'd0, 16'h0000);
      idle(1'b1);
      checkOutput("first_words_sent", 32'(wordsSentA), 32'd1);
      directedWord("enc_7FF", 11'h7FF, 1'b0, 1'b0, 4'd0, 4'd0, 16'hFFFF);
      directedWord("enc_400", 11'h400, 1'b0, 1'b0, 4'd0, 4'd0, 16'hE001);
      directedWord("inj_single", 11'h000, 1'b1, 1'b0, 4'd2, 4'd9, 16'h2000);
      idle(1'b1);
      checkOutput("inj_count_one", 32'(injCountA), 32'd1);
      directedWord("inj_double", 11'h000, 1'b1, 1'b1, 4'd0, 4'd5, 16'h8400);
      directedWord("inj_same_pos", 11'h000, 1'b1, 1'b1, 4'd5, 4'd5, 16'h0400);
      idle(1'b1);

      // Stall: two words fill the FIFO, the third is held off until space appears.
      applyStimulus(11'h123, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      applyStimulus(11'h456, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      applyStimulus(11'h789, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      checkOutput("full_in_ready", 32'(busA.in_ready), 32'd0);
      applyStimulus(11'h789, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
      applyStimulus(11'h789, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
      idle(1'b0);
      checkOutput("pushpop_out_valid", 32'(busA.out_valid), 32'd1);
      checkOutput("pushpop_in_ready", 32'(busA.in_ready), 32'd1);
      repeat (4) idle(1'b1);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(11'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0),
                       1'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7));
      end
      repeat (5) idle(1'b1);
      checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

      // Asynchronous reset while the FIFO is full and stalled.
      applyStimulus(11'h0AA, 1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 1'b0);
      applyStimulus(11'h155, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      idle(1'b0);
      checkOutput("prereset_full", 32'(busA.in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_out_valid", 32'(busA.out_valid), 32'd0);
      checkOutput("async_c_h", 32'(busA.c_h), 32'd0);
      checkOutput("async_words_sent", 32'(wordsSentA), 32'd0);
      checkOutput("async_inj_count", 32'(injCountA), 32'd0);
      checkOutput("async_in_ready", 32'(busA.in_ready), 32'd0);
      expQ.delete();
      pending = 1'b0;
      pendInj = 1'b0;
      modelSent = 0;
      modelInj = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) idle(1'b1);

      // Narrow counter instance with injection compiled out: 17 handshakes wrap to 1.
      busB.inj_en = 1'b1;
      busB.inj_pos_a = 4'd3;
      busB.in_valid = 1'b1;
      busB.out_ready = 1'b1;
      hs = 0;
      seenB = 1'b0;
      for (int cyc = 0; cyc < 200 && hs < 17; cyc++) begin
         @(negedge clk);
         #1;
         if (busB.out_valid) begin
            if (!seenB) checkOutput("noinj_c_h", 32'(busB.c_h), 32'd0);
            seenB = 1'b1;
            hs++;
         end
      end
      if (hs < 17) checkOutput("wrap_timeout", 32'(hs), 32'd17);
      @(negedge clk);
      #1;
      busB.in_valid = 1'b0;
      busB.out_ready = 1'b0;
      checkOutput("wrap_words_sent", 32'(wordsSentB), 32'd1);
      checkOutput("noinj_inj_count", 32'(injCountB), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
